piso_serializer: RTL and testbench

- Parametrised parallel-in/serial-out shifter; successor to the fixed 8-bit LSB-first serializer in the UART TX path.
- Adds configurable width and bit order, a valid/ready load handshake, baud-tick-paced shifting with an internal bit counter, an end-of-word pulse and a synchronous flush.
- Sits between the TX FIFO/controller and the frame mux that adds start/stop bits.

---
 rtl/piso_serializer.sv | 124 ++++++++++++
 tb/tb_piso_serializer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: parameterised parallel-in/serial-out shifter for the UART TX path.
// A word is loaded via a valid/ready handshake, then shifted one bit per baud tick.
// The bit order is selectable. An end-of-word pulse and a synchronous flush are provided.
// Optional feature macro: SER_PARITY_EN appends one parity bit period after the data bits.
// PARITY_ODD selects the parity sense when that macro is defined.
module piso_serializer #(
    parameter int   DATA_WIDTH = 8,
    parameter int   MSB_FIRST  = 0,
    parameter logic IDLE_LEVEL = 1'b1,
    parameter int   PARITY_ODD = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_p_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_tick,
    input  logic                  i_flush,
    output logic                  o_data_bit,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

`ifdef SER_PARITY_EN
    // The parity period is counted as one extra bit after the data bits.
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH);
`else
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
`endif

    // Reject illegal configurations at elaboration time.
    if (DATA_WIDTH < 2 || DATA_WIDTH > 32) begin : g_bad_width
        $error("piso_serializer: DATA_WIDTH must be in 2..32");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity
        $error("piso_serializer: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] sr;
    logic [DATA_WIDTH-1:0] sr_next;
    logic [CW-1:0]         cnt;
    logic                  done;
    logic                  accept;
    logic                  end_bit;
    logic                  shift_bit;

    assign accept  = (state == IDLE) && i_valid && !i_flush;
    assign end_bit = (MSB_FIRST != 0) ? sr[DATA_WIDTH-1] : sr[0];
    assign sr_next = (MSB_FIRST != 0) ? {sr[DATA_WIDTH-2:0], 1'b0}
                                      : {1'b0, sr[DATA_WIDTH-1:1]};

`ifdef SER_PARITY_EN
    logic par;

    // Capture the word parity at accept; flush and reset clear it.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            par <= 1'b0;
        end else if (i_flush) begin
            par <= 1'b0;
        end else if (accept) begin
            par <= (^i_p_data) ^ (PARITY_ODD != 0);
        end
    end

    // Once all data bits are consumed the counter sits on DATA_WIDTH for the parity period.
    assign shift_bit = (cnt == CW'(DATA_WIDTH)) ? par : end_bit;
`else
    assign shift_bit = end_bit;
`endif

    // Control FSM: load on accept, shift on tick, pulse done after the terminal tick.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (i_flush) begin
                state <= IDLE;
                sr    <= '0;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_valid) begin
                            sr    <= i_p_data;
                            cnt   <= '0;
                            state <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (i_tick) begin
                            if (cnt == LAST) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end else begin
                                sr  <= sr_next;
                                cnt <= cnt + CW'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign o_ready    = (state == IDLE);
    assign o_busy     = (state == SHIFT);
    assign o_done     = done;
    assign o_data_bit = (state == SHIFT) ? shift_bit : IDLE_LEVEL;

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: scoreboard bench for piso_serializer.
// Two instances share the same stimulus: LSB-first with even parity, and MSB-first with odd parity.
module tb_piso_serializer;

    localparam int DW = 8;
`ifdef SER_PARITY_EN
    localparam int NB = DW + 1;
`else
    localparam int NB = DW;
`endif

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic [DW-1:0] p_data = '0;
    logic          valid  = 1'b0;
    logic          tick   = 1'b0;
    logic          flush  = 1'b0;
    logic [1:0]    ready;
    logic [1:0]    data_bit;
    logic [1:0]    busy;
    logic [1:0]    done;

    int tests = 0;
    int fails = 0;
    bit expq[2][$];
    int donecnt[2] = '{0, 0};

    always #5 clk = ~clk;

    piso_serializer #(.DATA_WIDTH(DW), .MSB_FIRST(0), .IDLE_LEVEL(1'b1), .PARITY_ODD(0)) u_lsb (
        .i_clk(clk), .i_rst(rst_n), .i_p_data(p_data), .i_valid(valid), .o_ready(ready[0]),
        .i_tick(tick), .i_flush(flush), .o_data_bit(data_bit[0]), .o_busy(busy[0]), .o_done(done[0])
    );

    piso_serializer #(.DATA_WIDTH(DW), .MSB_FIRST(1), .IDLE_LEVEL(1'b1), .PARITY_ODD(1)) u_msb (
        .i_clk(clk), .i_rst(rst_n), .i_p_data(p_data), .i_valid(valid), .o_ready(ready[1]),
        .i_tick(tick), .i_flush(flush), .o_data_bit(data_bit[1]), .o_busy(busy[1]), .o_done(done[1])
    );

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s [inst %0d]: got %0h, expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Expected serial bits for each instance, in transmit order.
    function automatic void push_word(input logic [DW-1:0] w);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < DW; i++) begin
                expq[k].push_back(k == 0 ? w[i] : w[DW-1-i]);
            end
`ifdef SER_PARITY_EN
            expq[k].push_back(k == 0 ? ^w : ~^w);
`endif
            donecnt[k]++;
        end
    endfunction

    function automatic void clear_expect();
        for (int k = 0; k < 2; k++) begin
            expq[k].delete();
            donecnt[k] = 0;
        end
    endfunction

    // Monitor: compare every presented bit, pop on the tick that ends its period.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (busy[k] === 1'b1) begin
                check("ready_while_busy", k, ready[k], 1'b0);
                if (expq[k].size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_bit [inst %0d]: got busy with bit %0b, expected idle at %0t", k, data_bit[k], $time);
                end else begin
                    check("serial_bit", k, data_bit[k], expq[k][0]);
                    if (tick) void'(expq[k].pop_front());
                end
            end else if (rst_n) begin
                check("idle_level", k, data_bit[k], 1'b1);
                check("ready_when_idle", k, ready[k], 1'b1);
            end
            if (done[k] === 1'b1) begin
                tests++;
                if (donecnt[k] == 0) begin
                    fails++;
                    $display("FAIL unexpected_done [inst %0d]: got done=1, expected 0 at %0t", k, $time);
                end else begin
                    donecnt[k]--;
                end
                check("busy_at_done", k, busy[k], 1'b0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (done[0] !== 1'b1 && n < bound) begin
            cyc();
            n++;
        end
        tests++;
        if (done[0] !== 1'b1) begin
            fails++;
            $display("FAIL done_timeout: got no done within %0d cycles, expected done", bound);
        end
    endtask

    // Send one word with a tick every 'period' cycles; a tick in the accept cycle must be ignored.
    task automatic send(input logic [DW-1:0] w, input int period);
        int nbusy[2] = '{0, 0};
        push_word(w);
        p_data = w;
        valid  = 1'b1;
        tick   = 1'b1;
        cyc();
        valid = 1'b0;
        for (int c = 1; c <= NB * period; c++) begin
            tick = (c % period == 0);
            for (int k = 0; k < 2; k++) if (busy[k] === 1'b1) nbusy[k]++;
            cyc();
        end
        tick = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("done_after_last_tick", k, done[k], 1'b1);
            check("ready_at_done", k, ready[k], 1'b1);
            check("busy_cycles", k, nbusy[k], NB * period);
        end
    endtask

    initial begin
        // Reset values while reset is asserted.
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_ready", k, ready[k], 1'b1);
            check("rst_busy", k, busy[k], 1'b0);
            check("rst_done", k, done[k], 1'b0);
            check("rst_bit", k, data_bit[k], 1'b1);
        end
        cyc();
        rst_n = 1'b1;
        repeat (2) cyc();

        // Basic words at one bit per clock and one bit per 4 clocks.
        send(8'hA5, 1);
        cyc();
        send(8'hA5, 4);
        cyc();
        send(8'h07, 1);
        cyc();
        send(8'h80, 2);
        cyc();

        // Back-to-back: upstream holds valid; second word accepted in the done cycle.
        push_word(8'h0F);
        push_word(8'hF0);
        p_data = 8'h0F;
        valid  = 1'b1;
        tick   = 1'b1;
        cyc();
        p_data = 8'hF0;
        wait_done(40);
        for (int k = 0; k < 2; k++) begin
            check("b2b_ready_in_done", k, ready[k], 1'b1);
            check("b2b_gap_idle", k, data_bit[k], 1'b1);
        end
        cyc();
        valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("b2b_second_accepted", k, busy[k], 1'b1);
            check("b2b_done_one_cycle", k, done[k], 1'b0);
        end
        wait_done(40);
        tick = 1'b0;
        repeat (2) cyc();

        // Flush at bit 3 of 8'hFF: no done, idle next cycle.
        push_word(8'hFF);
        p_data = 8'hFF;
        valid  = 1'b1;
        tick   = 1'b1;
        cyc();
        valid = 1'b0;
        repeat (3) cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        tick  = 1'b0;
        clear_expect();
        for (int k = 0; k < 2; k++) begin
            check("flush_busy", k, busy[k], 1'b0);
            check("flush_ready", k, ready[k], 1'b1);
            check("flush_bit", k, data_bit[k], 1'b1);
        end
        repeat (3) cyc();

        // Flush wins over a simultaneous accept.
        p_data = 8'h55;
        valid  = 1'b1;
        flush  = 1'b1;
        cyc();
        valid = 1'b0;
        flush = 1'b0;
        for (int k = 0; k < 2; k++) check("flush_beats_accept", k, busy[k], 1'b0);
        repeat (2) cyc();

        // Valid while busy is ignored and must not be loaded afterwards.
        push_word(8'h3C);
        p_data = 8'h3C;
        valid  = 1'b1;
        tick   = 1'b1;
        cyc();
        p_data = 8'hC3;
        repeat (4) cyc();
        valid = 1'b0;
        wait_done(40);
        tick = 1'b0;
        repeat (3) cyc();
        for (int k = 0; k < 2; k++) check("busy_word_not_loaded", k, busy[k], 1'b0);

        // Async reset between edges during bit 5.
        push_word(8'hB6);
        p_data = 8'hB6;
        valid  = 1'b1;
        tick   = 1'b1;
        cyc();
        valid = 1'b0;
        repeat (5) cyc();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        clear_expect();
        #1;
        for (int k = 0; k < 2; k++) begin
            check("async_rst_busy", k, busy[k], 1'b0);
            check("async_rst_ready", k, ready[k], 1'b1);
            check("async_rst_bit", k, data_bit[k], 1'b1);
            check("async_rst_done", k, done[k], 1'b0);
        end
        tick = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        send(8'h01, 1);
        repeat (3) cyc();

        for (int k = 0; k < 2; k++) begin
            check("bits_left_over", k, expq[k].size(), 0);
            check("done_missing", k, donecnt[k], 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
